// File: rtl/sr_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sr_input_debounce
// Purpose  : Synchronises and debounces two raw active-low switch inputs
//            and drives clean registered active-low S/R for a NAND SR latch.
//            It also produces a one-cycle strobe when each output asserts.
// Option   : define SR_DEBOUNCE_INTERLOCK_EN to stop S and R from being low
//            together. When both qualify on the same edge, S takes priority.
// Revision : 1.0  initial release
// ============================================================================
module sr_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S_raw,
  input  logic R_raw,
  output logic S,
  output logic R,
  output logic S_fall,
  output logic R_fall
);

  // Per-channel debounce states; bit 1 set means the output is driven low
  localparam logic [1:0] c_idle_hi = 2'd0;
  localparam logic [1:0] c_chk_lo  = 2'd1;
  localparam logic [1:0] c_act_lo  = 2'd2;
  localparam logic [1:0] c_chk_hi  = 2'd3;

  localparam logic [CNT_W-1:0] c_deb    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_deb_m1 = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The counter must be able to hold DEBOUNCE_CYCLES, and DEBOUNCE_CYCLES must be at least 1
  generate
    if ((DEBOUNCE_CYCLES < 1) ||
        ((CNT_W < 31) && (DEBOUNCE_CYCLES > ((1 << CNT_W) - 1)))) begin : g_param_check
      $error("sr_input_debounce: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
    end
  endgenerate

  // Channel 0 is S, channel 1 is R
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0][1:0]       state_q, state_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            out_q, out_d;
  logic [1:0]            fall_q, fall_d;
  logic [1:0]            hold;

  // This function returns the next state and count for one channel.
  // A channel qualifies when this sample completes the stable run.
  // While the channel is held, the count stays at DEBOUNCE_CYCLES, so it still qualifies.
  function automatic void fsm_next(
    input  logic [1:0]       st,
    input  logic [CNT_W-1:0] cnt,
    input  logic             smp,
    input  logic             hold_low,
    output logic [1:0]       st_n,
    output logic [CNT_W-1:0] cnt_n
  );
    logic qual;
    qual  = (cnt >= c_deb_m1);
    st_n  = st;
    cnt_n = cnt;
    case (st)
      c_idle_hi, c_chk_lo: begin
        if (smp) begin
          st_n  = c_idle_hi;
          cnt_n = '0;
        end else if (!qual) begin
          st_n  = c_chk_lo;
          cnt_n = cnt + 1'b1;
        end else if (hold_low) begin
          st_n  = c_chk_lo;
          cnt_n = c_deb;
        end else begin
          st_n  = c_act_lo;
          cnt_n = '0;
        end
      end
      default: begin
        if (!smp) begin
          st_n  = c_act_lo;
          cnt_n = '0;
        end else if (!qual) begin
          st_n  = c_chk_hi;
          cnt_n = cnt + 1'b1;
        end else begin
          st_n  = c_idle_hi;
          cnt_n = '0;
        end
      end
    endcase
  endfunction

  // Two-flop synchroniser inputs
  always_comb begin
    sync1_d = {R_raw, S_raw};
    sync2_d = sync1_q;
  end

  // Next state: S is evaluated first so R can see whether S is going low on this edge
  always_comb begin
    hold = '0;
`ifdef SR_DEBOUNCE_INTERLOCK_EN
    hold[0] = ~out_q[1];
`endif
    fsm_next(state_q[0], cnt_q[0], sync2_q[0], hold[0], state_d[0], cnt_d[0]);
`ifdef SR_DEBOUNCE_INTERLOCK_EN
    hold[1] = ~out_q[0] | (state_d[0] == c_act_lo);
`endif
    fsm_next(state_q[1], cnt_q[1], sync2_q[1], hold[1], state_d[1], cnt_d[1]);
  end

  // Outputs decode from the next state; a strobe marks a 1->0 output change
  always_comb begin
    out_d[0]  = (state_d[0] == c_idle_hi) || (state_d[0] == c_chk_lo);
    out_d[1]  = (state_d[1] == c_idle_hi) || (state_d[1] == c_chk_lo);
    fall_d    = out_q & ~out_d;
  end

  // State register: reset discards all history and forces both outputs high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      state_q <= {c_idle_hi, c_idle_hi};
      cnt_q   <= '0;
      out_q   <= 2'b11;
      fall_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      fall_q  <= fall_d;
    end
  end

  assign S      = out_q[0];
  assign R      = out_q[1];
  assign S_fall = fall_q[0];
  assign R_fall = fall_q[1];

endmodule
`default_nettype wire

// File: tb/tb_sr_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_input_debounce
// Purpose  : Self-checking bench for sr_input_debounce with DEBOUNCE_CYCLES=4.
//            For each cycle, the bench queues the expected {S,R,S_fall,R_fall} when it drives the stimulus.
//            The monitor then compares that value after the following clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_sr_input_debounce;

  localparam int DEB = 4;

  // Expected output vectors, ordered {S, R, S_fall, R_fall}
  localparam logic [3:0] V_IDLE   = 4'b1100;
  localparam logic [3:0] V_S_FALL = 4'b0110;
  localparam logic [3:0] V_S_LO   = 4'b0100;
  localparam logic [3:0] V_R_FALL = 4'b1001;
  localparam logic [3:0] V_R_LO   = 4'b1000;
  localparam logic [3:0] V_BOTH_F = 4'b0011;
  localparam logic [3:0] V_BOTH   = 4'b0000;

  typedef struct packed {
    int         id;
    logic [3:0] v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic S_raw = 1'b1;
  logic R_raw = 1'b1;
  logic S, R, S_fall, R_fall;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  sr_input_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .S_raw (S_raw),
    .R_raw (R_raw),
    .S     (S),
    .R     (R),
    .S_fall(S_fall),
    .R_fall(R_fall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive one cycle of raw inputs and queue the outputs expected after the next edge
  task automatic cyc(input logic s, input logic r, input logic [3:0] e);
    S_raw = s;
    R_raw = r;
    sb.push_back('{id: step_id, v: e});
    step_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic s, input logic r, input logic [3:0] e);
    repeat (n) cyc(s, r, e);
  endtask

  // Monitor: after each edge, compare the outputs with the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check($sformatf("out_step%0d", mon_e.id), {28'd0, S, R, S_fall, R_fall}, {28'd0, mon_e.v});
    end
  end

  initial begin
    // Reset asserted between clock edges must take effect without a clock
    #2 rst_n = 1'b0;
    #1 check("rst_init", {28'd0, S, R, S_fall, R_fall}, {28'd0, V_IDLE});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_held", {28'd0, S, R, S_fall, R_fall}, {28'd0, V_IDLE});
    rst_n = 1'b1;

    // Idle: both inputs high for 20 cycles
    run(20, 1'b1, 1'b1, V_IDLE);

    // S press and release; each change takes DEB+2 edges
    run(DEB + 1, 1'b0, 1'b1, V_IDLE);
    cyc(1'b0, 1'b1, V_S_FALL);
    run(2, 1'b0, 1'b1, V_S_LO);
    run(DEB + 1, 1'b1, 1'b1, V_S_LO);
    cyc(1'b1, 1'b1, V_IDLE);
    run(2, 1'b1, 1'b1, V_IDLE);

    // R glitches: two 3-cycle pulses with a 1-cycle gap are rejected
    run(3, 1'b1, 1'b0, V_IDLE);
    cyc(1'b1, 1'b1, V_IDLE);
    run(3, 1'b1, 1'b0, V_IDLE);
    run(6, 1'b1, 1'b1, V_IDLE);
    // A 5-cycle pulse is accepted, then released
    run(5, 1'b1, 1'b0, V_IDLE);
    cyc(1'b1, 1'b1, V_R_FALL);
    run(DEB, 1'b1, 1'b1, V_R_LO);
    cyc(1'b1, 1'b1, V_IDLE);
    run(2, 1'b1, 1'b1, V_IDLE);

    // Reset while S is debounced low, then recovery with S_raw still low
    run(DEB + 1, 1'b0, 1'b1, V_IDLE);
    cyc(1'b0, 1'b1, V_S_FALL);
    run(3, 1'b0, 1'b1, V_S_LO);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_async", {28'd0, S, R, S_fall, R_fall}, {28'd0, V_IDLE});
    @(posedge clk); #1;
    check("rst_mid_held", {28'd0, S, R, S_fall, R_fall}, {28'd0, V_IDLE});
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(DEB + 1, 1'b0, 1'b1, V_IDLE);
    cyc(1'b0, 1'b1, V_S_FALL);
    run(2, 1'b0, 1'b1, V_S_LO);
    run(DEB + 1, 1'b1, 1'b1, V_S_LO);
    cyc(1'b1, 1'b1, V_IDLE);
    run(2, 1'b1, 1'b1, V_IDLE);

    // Both inputs drop together
    run(DEB + 1, 1'b0, 1'b0, V_IDLE);
`ifdef SR_DEBOUNCE_INTERLOCK_EN
    // S wins; R waits until S has returned high
    cyc(1'b0, 1'b0, V_S_FALL);
    run(2, 1'b0, 1'b0, V_S_LO);
    run(DEB + 1, 1'b1, 1'b0, V_S_LO);
    cyc(1'b1, 1'b0, V_IDLE);
    cyc(1'b1, 1'b0, V_R_FALL);
    run(2, 1'b1, 1'b0, V_R_LO);
    run(DEB + 1, 1'b1, 1'b1, V_R_LO);
    cyc(1'b1, 1'b1, V_IDLE);
    run(2, 1'b1, 1'b1, V_IDLE);
`else
    // Independent channels: both assert together
    cyc(1'b0, 1'b0, V_BOTH_F);
    run(2, 1'b0, 1'b0, V_BOTH);
    run(DEB + 1, 1'b1, 1'b1, V_BOTH);
    cyc(1'b1, 1'b1, V_IDLE);
    run(2, 1'b1, 1'b1, V_IDLE);
`endif

    // Let the monitor consume the final expectation
    @(posedge clk); #2;
    check("sb_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
